// File: rtl/flag_ctx_ctrl_if.sv
// Bus between the CPU core and the flag-context controller.
// The master drives the flag/interrupt/condition requests; the slave answers.
interface flag_ctx_ctrl_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned DW = $clog2(DEPTH) + 1;

    logic          alu_valid;
    logic [3:0]    alu_flags;
    logic [3:0]    cur_flags;
    logic          int_enter;
    logic          int_return;
    logic          cond_req;
    logic [3:0]    cond_code;
    logic          err_clr;

    logic          flags_en;
    logic          flags_src_sel;
    logic [3:0]    flags_restore;
    logic          cond_valid;
    logic          cond_taken;
    logic          busy;
    logic [DW-1:0] stack_depth;
    logic          stack_full;
    logic          stack_empty;
    logic          err_overflow;
    logic          err_underflow;

    modport master (
        output alu_valid, alu_flags, cur_flags, int_enter, int_return,
               cond_req, cond_code, err_clr,
        input  flags_en, flags_src_sel, flags_restore, cond_valid, cond_taken,
               busy, stack_depth, stack_full, stack_empty, err_overflow, err_underflow
    );

    modport slave (
        input  alu_valid, alu_flags, cur_flags, int_enter, int_return,
               cond_req, cond_code, err_clr,
        output flags_en, flags_src_sel, flags_restore, cond_valid, cond_taken,
               busy, stack_depth, stack_full, stack_empty, err_overflow, err_underflow
    );
endinterface

// File: rtl/flag_ctx_ctrl.sv
// Flag-context controller: saves/restores {Z,N,C,V} across interrupts on a small
// LIFO and evaluates branch condition codes against the live flags.
module flag_ctx_ctrl #(
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    flag_ctx_ctrl_if.slave bus
);
    localparam int unsigned DW = $clog2(DEPTH) + 1;
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic {
        IDLE    = 1'b0,
        RESTORE = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    stack_q [DEPTH];
    logic [DW-1:0] depth_q, depth_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          cond_valid_q, cond_valid_d;
    logic          cond_taken_q, cond_taken_d;

    logic          full, empty;
    logic          push, pop;
    logic          ovf_set, unf_set;
    logic [3:0]    push_data;
    logic [AW-1:0] push_idx, top_idx;
    logic          busy;

    // {Z,N,C,V} condition decode
    function automatic logic cond_eval(input logic [3:0] f, input logic [3:0] code);
        logic z, n, c, v, r;
        {z, n, c, v} = f;
        r = 1'b0;
        case (code)
            4'd0:  r = 1'b1;
            4'd1:  r = z;
            4'd2:  r = ~z;
            4'd3:  r = n;
            4'd4:  r = ~n;
            4'd5:  r = c;
            4'd6:  r = ~c;
            4'd7:  r = v;
            4'd8:  r = ~v;
            4'd9:  r = c & ~z;
            4'd10: r = ~c | z;
            4'd11: r = (n == v);
            4'd12: r = (n != v);
            4'd13: r = ~z & (n == v);
            4'd14: r = z | (n != v);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign full      = (depth_q == DW'(DEPTH));
    assign empty     = (depth_q == '0);
    assign push_idx  = depth_q[AW-1:0];
    assign top_idx   = AW'(depth_q - DW'(1));
    assign push_data = bus.alu_valid ? bus.alu_flags : bus.cur_flags;
    assign busy      = (state_q == RESTORE);

    // Next-state: interrupt entry beats return; RESTORE is a single pop cycle
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        pop     = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.int_enter) begin
                    if (full) ovf_set = 1'b1;
                    else      push    = 1'b1;
                end else if (bus.int_return) begin
                    if (empty) unf_set = 1'b1;
                    else       state_d = RESTORE;
                end
            end
            RESTORE: begin
                pop     = ~empty;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        depth_d = depth_q;
        if (push)     depth_d = depth_q + DW'(1);
        else if (pop) depth_d = depth_q - DW'(1);

        ovf_d = (ovf_q & ~bus.err_clr) | ovf_set;
        unf_d = (unf_q & ~bus.err_clr) | unf_set;

        cond_valid_d = bus.cond_req;
        cond_taken_d = bus.cond_req & cond_eval(bus.cur_flags, bus.cond_code);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            depth_q      <= '0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
            cond_valid_q <= 1'b0;
            cond_taken_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) stack_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            depth_q      <= depth_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
            cond_valid_q <= cond_valid_d;
            cond_taken_q <= cond_taken_d;
            if (push) stack_q[push_idx] <= push_data;
        end
    end

    // The flags-register write port is steered directly by the state decode
    assign bus.flags_en      = busy | bus.alu_valid;
    assign bus.flags_src_sel = busy;
    assign bus.flags_restore = busy ? stack_q[top_idx] : 4'b0000;
    assign bus.busy          = busy;
    assign bus.cond_valid    = cond_valid_q;
    assign bus.cond_taken    = cond_taken_q;
    assign bus.stack_depth   = depth_q;
    assign bus.stack_full    = full;
    assign bus.stack_empty   = empty;
    assign bus.err_overflow  = ovf_q;
    assign bus.err_underflow = unf_q;
endmodule

// File: tb/tb_flag_ctx_ctrl.sv
// Directed bench for flag_ctx_ctrl; condition results are checked through a
// scoreboard queue filled when each request is driven.
module tb_flag_ctx_ctrl;
    logic clk;
    logic reset;
    int   tests;
    int   fails;
    logic exp_q [$];

    flag_ctx_ctrl_if #(.DEPTH(4)) ifc ();

    flag_ctx_ctrl #(.DEPTH(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic model(input logic [3:0] f, input logic [3:0] code);
        logic z, n, c, v;
        z = f[3]; n = f[2]; c = f[1]; v = f[0];
        case (code)
            4'd0:  return 1'b1;
            4'd1:  return z;
            4'd2:  return !z;
            4'd3:  return n;
            4'd4:  return !n;
            4'd5:  return c;
            4'd6:  return !c;
            4'd7:  return v;
            4'd8:  return !v;
            4'd9:  return c && !z;
            4'd10: return !c || z;
            4'd11: return n == v;
            4'd12: return n != v;
            4'd13: return !z && (n == v);
            4'd14: return z || (n != v);
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then retire any condition result against the scoreboard
    task automatic tick();
        logic e;
        @(posedge clk);
        #1;
        if (ifc.cond_valid !== 1'b0) begin
            chk("cond_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("cond_taken", 32'(ifc.cond_taken), 32'(e));
            end
        end
    endtask

    task automatic idle_inputs();
        ifc.alu_valid  = 1'b0;
        ifc.int_enter  = 1'b0;
        ifc.int_return = 1'b0;
        ifc.cond_req   = 1'b0;
        ifc.err_clr    = 1'b0;
    endtask

    initial begin
        logic [3:0] fl [7];
        tests = 0;
        fails = 0;
        fl = '{4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0110, 4'b1001};
        reset         = 1'b0;
        ifc.alu_flags = 4'b0000;
        ifc.cur_flags = 4'b0000;
        ifc.cond_code = 4'd0;
        idle_inputs();

        // Reset values
        #3;
        chk("rst_busy",     32'(ifc.busy),          32'd0);
        chk("rst_depth",    32'(ifc.stack_depth),   32'd0);
        chk("rst_empty",    32'(ifc.stack_empty),   32'd1);
        chk("rst_full",     32'(ifc.stack_full),    32'd0);
        chk("rst_src_sel",  32'(ifc.flags_src_sel), 32'd0);
        chk("rst_restore",  32'(ifc.flags_restore), 32'd0);
        chk("rst_cvalid",   32'(ifc.cond_valid),    32'd0);
        chk("rst_ctaken",   32'(ifc.cond_taken),    32'd0);
        chk("rst_ovf",      32'(ifc.err_overflow),  32'd0);
        chk("rst_unf",      32'(ifc.err_underflow), 32'd0);
        #10;
        reset = 1'b1;
        tick();

        // Save / restore
        ifc.cur_flags = 4'b1010;
        ifc.int_enter = 1'b1;
        #1;
        chk("s1_no_write", 32'(ifc.flags_en), 32'd0);
        tick();
        ifc.int_enter = 1'b0;
        chk("s1_depth1", 32'(ifc.stack_depth), 32'd1);
        ifc.alu_valid = 1'b1;
        ifc.alu_flags = 4'b0101;
        #1;
        chk("s1_alu_en",  32'(ifc.flags_en),      32'd1);
        chk("s1_alu_src", 32'(ifc.flags_src_sel), 32'd0);
        tick();
        ifc.alu_valid  = 1'b0;
        ifc.cur_flags  = 4'b0101;
        ifc.int_return = 1'b1;
        #1;
        chk("s1_ret_not_busy", 32'(ifc.busy), 32'd0);
        tick();
        ifc.int_return = 1'b0;
        chk("s1_rst_en",      32'(ifc.flags_en),      32'd1);
        chk("s1_rst_src",     32'(ifc.flags_src_sel), 32'd1);
        chk("s1_rst_data",    32'(ifc.flags_restore), 32'hA);
        chk("s1_rst_busy",    32'(ifc.busy),          32'd1);
        tick();
        chk("s1_after_depth", 32'(ifc.stack_depth), 32'd0);
        chk("s1_after_empty", 32'(ifc.stack_empty), 32'd1);
        chk("s1_after_busy",  32'(ifc.busy),        32'd0);
        chk("s1_after_en",    32'(ifc.flags_en),    32'd0);

        // Save concurrent with an ALU write: the ALU result is what gets saved
        ifc.alu_valid = 1'b1;
        ifc.alu_flags = 4'b0011;
        ifc.cur_flags = 4'b1100;
        ifc.int_enter = 1'b1;
        #1;
        chk("s2_en",  32'(ifc.flags_en),      32'd1);
        chk("s2_src", 32'(ifc.flags_src_sel), 32'd0);
        tick();
        idle_inputs();
        ifc.cur_flags = 4'b0011;
        chk("s2_depth", 32'(ifc.stack_depth), 32'd1);
        ifc.int_return = 1'b1;
        tick();
        ifc.int_return = 1'b0;
        chk("s2_restore", 32'(ifc.flags_restore), 32'h3);
        tick();
        chk("s2_depth0", 32'(ifc.stack_depth), 32'd0);

        // Overflow: five entries into a four-deep stack
        ifc.int_enter = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ifc.cur_flags = 4'(i + 4);
            tick();
            if (i == 3) begin
                chk("ov_depth4", 32'(ifc.stack_depth),  32'd4);
                chk("ov_full",   32'(ifc.stack_full),   32'd1);
                chk("ov_noerr",  32'(ifc.err_overflow), 32'd0);
            end
        end
        ifc.int_enter = 1'b0;
        chk("ov_err",       32'(ifc.err_overflow), 32'd1);
        chk("ov_depth_hold", 32'(ifc.stack_depth), 32'd4);

        // Drain in LIFO order, then underflow
        for (int i = 3; i >= 0; i--) begin
            ifc.int_return = 1'b1;
            tick();
            ifc.int_return = 1'b0;
            chk("drain_data", 32'(ifc.flags_restore), 32'(i + 4));
            tick();
        end
        chk("drain_empty", 32'(ifc.stack_empty),   32'd1);
        chk("drain_nounf", 32'(ifc.err_underflow), 32'd0);
        ifc.int_return = 1'b1;
        tick();
        ifc.int_return = 1'b0;
        chk("un_err",   32'(ifc.err_underflow), 32'd1);
        chk("un_idle",  32'(ifc.busy),          32'd0);
        chk("un_depth", 32'(ifc.stack_depth),   32'd0);
        tick();
        chk("un_sticky", 32'(ifc.err_underflow), 32'd1);
        // Clear coinciding with a fresh underflow keeps the bit set
        ifc.int_return = 1'b1;
        ifc.err_clr    = 1'b1;
        tick();
        idle_inputs();
        chk("clr_collide_unf", 32'(ifc.err_underflow), 32'd1);
        chk("clr_collide_ovf", 32'(ifc.err_overflow),  32'd0);
        ifc.err_clr = 1'b1;
        tick();
        ifc.err_clr = 1'b0;
        chk("clr_unf", 32'(ifc.err_underflow), 32'd0);
        chk("clr_ovf", 32'(ifc.err_overflow),  32'd0);

        // Condition table, back-to-back requests
        for (int i = 0; i < 7; i++) begin
            for (int c = 0; c < 16; c++) begin
                ifc.cur_flags = fl[i];
                ifc.cond_code = 4'(c);
                ifc.cond_req  = 1'b1;
                exp_q.push_back(model(fl[i], 4'(c)));
                tick();
            end
        end
        ifc.cond_req = 1'b0;
        tick();
        chk("cond_pulse_end", 32'(ifc.cond_valid), 32'd0);

        // Condition sees pre-update flags while an ALU write is in flight
        ifc.cur_flags = 4'b0100;
        ifc.alu_flags = 4'b1000;
        ifc.alu_valid = 1'b1;
        ifc.cond_code = 4'd1;
        ifc.cond_req  = 1'b1;
        exp_q.push_back(model(4'b0100, 4'd1));
        tick();
        idle_inputs();
        chk("cond_pre_valid", 32'(ifc.cond_valid), 32'd1);
        tick();
        chk("cond_single", 32'(ifc.cond_valid), 32'd0);

        // Simultaneous enter+return with depth 1
        ifc.cur_flags = 4'b0001;
        ifc.int_enter = 1'b1;
        tick();
        ifc.cur_flags  = 4'b0010;
        ifc.int_return = 1'b1;
        tick();
        idle_inputs();
        chk("sim_depth2", 32'(ifc.stack_depth),   32'd2);
        chk("sim_nobusy", 32'(ifc.busy),          32'd0);
        chk("sim_noovf",  32'(ifc.err_overflow),  32'd0);
        chk("sim_nounf",  32'(ifc.err_underflow), 32'd0);
        tick();
        chk("sim_still_idle", 32'(ifc.busy), 32'd0);

        // Requests during RESTORE are ignored
        ifc.int_return = 1'b1;
        tick();
        ifc.int_enter  = 1'b1;
        ifc.alu_valid  = 1'b1;
        #1;
        chk("rs_busy",  32'(ifc.busy),          32'd1);
        chk("rs_src",   32'(ifc.flags_src_sel), 32'd1);
        chk("rs_data",  32'(ifc.flags_restore), 32'h2);
        tick();
        idle_inputs();
        chk("rs_depth1",   32'(ifc.stack_depth),  32'd1);
        chk("rs_idle",     32'(ifc.busy),         32'd0);
        chk("rs_noovf",    32'(ifc.err_overflow), 32'd0);

        // Reset during RESTORE aborts the pop
        ifc.int_return = 1'b1;
        tick();
        ifc.int_return = 1'b0;
        chk("rr_busy", 32'(ifc.busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("rr_busy0",  32'(ifc.busy),          32'd0);
        chk("rr_depth0", 32'(ifc.stack_depth),   32'd0);
        chk("rr_src0",   32'(ifc.flags_src_sel), 32'd0);
        chk("rr_en0",    32'(ifc.flags_en),      32'd0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rr_post_en",    32'(ifc.flags_en),      32'd0);
            chk("rr_post_src",   32'(ifc.flags_src_sel), 32'd0);
            chk("rr_post_busy",  32'(ifc.busy),          32'd0);
            chk("rr_post_empty", 32'(ifc.stack_empty),   32'd1);
        end

        chk("cond_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
